// File: rtl/dct_quant.sv
// Quantiser for DCT coefficient rows: reciprocal multiply by a programmable 8x8 table,
// round half away from zero, saturate. Fixed two-cycle latency with framing passthrough.
module dct_quant #(
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned OUT_W   = 12,
    parameter int unsigned RECIP_W = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [7:0][COEF_W-1:0]       in_data,
    input  logic                         in_eob,
    input  logic                         in_sob,
    input  logic                         in_sof,
    input  logic                         tbl_we,
    input  logic [5:0]                   tbl_addr,
    input  logic [RECIP_W-1:0]           tbl_data,
    output logic                         out_valid,
    output logic [7:0][OUT_W-1:0]        out_data,
    output logic                         out_eob,
    output logic                         out_sob,
    output logic                         out_sof,
    output logic                         err_proto
);

    localparam int unsigned AbsW  = COEF_W + 1;
    localparam int unsigned ProdW = AbsW + RECIP_W;
    localparam int unsigned MagW  = ProdW - 16;

    localparam logic [RECIP_W-1:0] TblReset = RECIP_W'(65536);
    localparam logic [ProdW-1:0]   RoundAdd = ProdW'(32768);
    localparam logic [MagW-1:0]    MaxPos   = MagW'((1 << (OUT_W - 1)) - 1);
    localparam logic [MagW-1:0]    MaxNeg   = MagW'(1 << (OUT_W - 1));
    localparam logic [OUT_W-1:0]   SatPos   = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]   SatNeg   = {1'b1, {(OUT_W - 1){1'b0}}};

    // Reciprocal table
    logic [RECIP_W-1:0] tbl_q [64];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                tbl_q[i] <= TblReset;
            end
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    // Row tracking and framing check
    logic [2:0] row_q, row_d, beat_row;
    logic       err_d;

    always_comb begin
        beat_row = in_sob ? 3'd0 : row_q;
        row_d    = in_valid ? beat_row + 3'd1 : row_q;
        err_d    = in_valid && ((in_sob && (row_q != 3'd0)) ||
                                ((beat_row == 3'd7) && !in_eob) ||
                                (in_eob && (beat_row != 3'd7)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= 3'd0;
        end else begin
            row_q <= row_d;
        end
    end

    // Stage 1: magnitude times reciprocal
    logic [ProdW-1:0] prod_d [8];
    logic [7:0]       sign_d;

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            logic [AbsW-1:0] ext;
            logic [AbsW-1:0] mag;
            ext       = {in_data[c][COEF_W-1], in_data[c]};
            sign_d[c] = in_data[c][COEF_W-1];
            // Extra bit keeps |most negative| representable
            mag       = sign_d[c] ? (~ext + AbsW'(1)) : ext;
            prod_d[c] = ProdW'(mag) * ProdW'(tbl_q[{beat_row, 3'(c)}]);
        end
    end

    logic [ProdW-1:0] s1_prod_q [8];
    logic [7:0]       s1_sign_q;
    logic             s1_valid_q, s1_eob_q, s1_sob_q, s1_sof_q, s1_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 8; c++) begin
                s1_prod_q[c] <= '0;
            end
            s1_sign_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_eob_q   <= 1'b0;
            s1_sob_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < 8; c++) begin
                s1_prod_q[c] <= prod_d[c];
            end
            s1_sign_q  <= sign_d;
            s1_valid_q <= in_valid;
            s1_eob_q   <= in_eob;
            s1_sob_q   <= in_sob;
            s1_sof_q   <= in_sof;
            s1_err_q   <= err_d;
        end
    end

    // Stage 2: round, restore sign, saturate
    logic [7:0][OUT_W-1:0] q_d;

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            logic [ProdW-1:0] rnd;
            logic [MagW-1:0]  mag;
            rnd = (s1_prod_q[c] + RoundAdd) >> 16;
            mag = MagW'(rnd);
            if (!s1_sign_q[c]) begin
                q_d[c] = (mag > MaxPos) ? SatPos : OUT_W'(mag);
            end else begin
                q_d[c] = (mag > MaxNeg) ? SatNeg : OUT_W'(~mag + MagW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eob   <= 1'b0;
            out_sob   <= 1'b0;
            out_sof   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            out_valid <= s1_valid_q;
            out_data  <= q_d;
            out_eob   <= s1_eob_q;
            out_sob   <= s1_sob_q;
            out_sof   <= s1_sof_q;
            err_proto <= s1_valid_q && s1_err_q;
        end
    end

endmodule

// File: tb/tb_dct_quant.sv
// Directed bench for dct_quant: drives rows and table writes, checks every output beat
// and every idle cycle against a reference quantiser and framing model.
module tb_dct_quant;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [7:0][15:0]      in_data;
    logic                  in_eob, in_sob, in_sof;
    logic                  tbl_we;
    logic [5:0]            tbl_addr;
    logic [16:0]           tbl_data;
    logic                  out_valid;
    logic [7:0][11:0]      out_data;
    logic                  out_eob, out_sob, out_sof;
    logic                  err_proto;

    dct_quant #(
        .COEF_W  (16),
        .OUT_W   (12),
        .RECIP_W (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_eob    (in_eob),
        .in_sob    (in_sob),
        .in_sof    (in_sof),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eob   (out_eob),
        .out_sob   (out_sob),
        .out_sof   (out_sof),
        .err_proto (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [7:0][11:0] d;
        logic             sob, eob, sof, err;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int unsigned mtbl[64];
    int          mrow;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint quant(input longint c, input longint r);
        longint a, m, q;
        a = (c < 0) ? -c : c;
        m = (a * r + 32768) >>> 16;
        q = (c < 0) ? -m : m;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return q;
    endfunction

    function automatic logic [7:0][15:0] fill(input int v);
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = 16'(v);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mtbl[i] = 65536;
        mrow = 0;
    endtask

    task automatic send_row(input logic [7:0][15:0] d, input bit sob, input bit eob,
                            input bit sof, input bit use_exp = 1'b0,
                            input logic [7:0][11:0] xd = '0);
        exp_t e;
        int   br;
        @(posedge clk); #2;
        tbl_we   = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
        br       = sob ? 0 : mrow;
        e.due    = cyc + 2;
        e.sob    = sob;
        e.eob    = eob;
        e.sof    = sof;
        e.err    = (sob && mrow != 0) || (br == 7 && !eob) || (eob && br != 7);
        for (int c = 0; c < 8; c++) begin
            e.d[c] = use_exp ? xd[c] : 12'(quant(longint'($signed(d[c])), mtbl[br*8+c]));
        end
        exp_q.push_back(e);
        mrow = (br + 1) % 8;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
            tbl_we   = 1'b0;
            in_sob   = 1'b0;
            in_eob   = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic tbl_write(input int addr, input int unsigned val);
        @(posedge clk); #2;
        in_valid = 1'b0;
        tbl_we   = 1'b1;
        tbl_addr = 6'(addr);
        tbl_data = 17'(val);
        mtbl[addr] = val;
    endtask

    task automatic send_block(input logic [7:0][15:0] d, input bit sof,
                              input bit use_exp = 1'b0, input logic [7:0][11:0] xd = '0);
        for (int r = 0; r < 8; r++) send_row(d, r == 0, r == 7, sof && r == 0, use_exp, xd);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check_eq("row_due_cycle", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check_eq("out_valid", out_valid, 1);
                for (int c = 0; c < 8; c++) begin
                    check_eq($sformatf("out_data[%0d]", c), $signed(out_data[c]),
                             $signed(exp_q[0].d[c]));
                end
                check_eq("out_sob", out_sob, exp_q[0].sob);
                check_eq("out_eob", out_eob, exp_q[0].eob);
                check_eq("out_sof", out_sof, exp_q[0].sof);
                check_eq("err_proto", err_proto, exp_q[0].err);
                void'(exp_q.pop_front());
            end else begin
                check_eq("idle_valid", out_valid, 0);
                check_eq("idle_err", err_proto, 0);
            end
        end
    end

    initial begin
        logic [7:0][15:0] rd;
        logic [7:0][11:0] rx;
        exp_t             keep[$];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sob = 1'b0; in_eob = 1'b0;
        in_sof = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_sob", out_sob, 0);
        check_eq("rst_eob", out_eob, 0);
        check_eq("rst_sof", out_sof, 0);
        check_eq("rst_err", err_proto, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Default table, back-to-back blocks
        rx = '0;
        for (int c = 0; c < 8; c++) rx[c] = 12'(100);
        send_block(fill(100), 1'b1, 1'b1, rx);
        for (int c = 0; c < 8; c++) rx[c] = 12'(-100);
        send_block(fill(-100), 1'b0, 1'b1, rx);
        idle(3);

        // Q = 16 everywhere: rounding half away from zero
        for (int i = 0; i < 64; i++) tbl_write(i, 4096);
        rd[0] = 16'(24); rd[1] = 16'(-24); rd[2] = 16'(23); rd[3] = 16'(-23);
        rd[4] = 16'(8);  rd[5] = 16'(-8);  rd[6] = 16'(7);  rd[7] = 16'(0);
        rx[0] = 12'(2);  rx[1] = 12'(-2);  rx[2] = 12'(1);  rx[3] = 12'(-1);
        rx[4] = 12'(1);  rx[5] = 12'(-1);  rx[6] = 12'(0);  rx[7] = 12'(0);
        send_block(rd, 1'b0, 1'b1, rx);

        // Back to pass-through: saturation
        for (int i = 0; i < 64; i++) tbl_write(i, 65536);
        rd[0] = 16'(30000); rd[1] = 16'(-32768); rd[2] = 16'(2047); rd[3] = 16'(-2048);
        rd[4] = 16'(-2049); rd[5] = 16'(0);      rd[6] = 16'(0);    rd[7] = 16'(0);
        rx[0] = 12'(2047);  rx[1] = 12'(-2048);  rx[2] = 12'(2047); rx[3] = 12'(-2048);
        rx[4] = 12'(-2048); rx[5] = 12'(0);      rx[6] = 12'(0);    rx[7] = 12'(0);
        send_block(rd, 1'b0, 1'b1, rx);

        // Per-position table
        for (int i = 0; i < 64; i++) tbl_write(i, 65536 / (i + 1));
        send_block(fill(1000), 1'b1);

        // sob on the 4th row, then resync to a clean eob
        for (int r = 0; r < 3; r++) send_row(fill(1000), r == 0, 1'b0, 1'b0);
        send_row(fill(1000), 1'b1, 1'b0, 1'b0);
        for (int r = 1; r < 8; r++) send_row(fill(1000), 1'b0, r == 7, 1'b0);

        // Missing eob on row 7, then a normal block
        for (int r = 0; r < 8; r++) send_row(fill(777), r == 0, 1'b0, 1'b0);
        send_block(fill(-500), 1'b0);

        // Random gaps and random data
        for (int r = 0; r < 8; r++) begin
            idle($urandom_range(0, 36));
            for (int c = 0; c < 8; c++) rd[c] = 16'($urandom);
            send_row(rd, r == 0, r == 7, 1'b0);
        end

        // Reset mid-block after row 3
        for (int r = 0; r < 4; r++) send_row(fill(1000), r == 0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1; in_valid = 1'b0; tbl_we = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep.push_back(exp_q[i]);
        exp_q = keep;
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        idle(2);
        for (int c = 0; c < 8; c++) rx[c] = 12'(100);
        send_block(fill(100), 1'b1, 1'b1, rx);

        idle(6);
        check_eq("drain_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
